// File: rtl/shreg_cmd_sequencer.sv
// Command sequencer for the 4-bit universal shift register: queues multi-beat commands in a FIFO
// and expands each command into registered per-cycle M/D/SI beats, with no gaps between commands.
module shreg_cmd_sequencer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  output logic [1:0] M,
  output logic [3:0] D,
  output logic       SI,
  output logic       done,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [8:0] head;
  logic [1:0] head_op;
  logic [2:0] head_cnt;
  logic [3:0] head_data;

  state_t     state;
  logic [1:0] op;
  logic [2:0] cnt;
  logic [3:0] data;
  logic [2:0] beat;
  logic [2:0] next_beat;
  logic [2:0] last_beat;
  logic       at_last;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;

  assign head      = mem[rd_ptr];
  assign head_op   = head[8:7];
  assign head_cnt  = head[6:4];
  assign head_data = head[3:0];

  // LOAD is always a single beat regardless of the count field
  assign last_beat = (op == OP_LOAD) ? 3'd0 : cnt;
  assign at_last   = (state == RUN) && (beat == last_beat);
  assign next_beat = beat + 3'd1;
  assign pop       = !empty && ((state == IDLE) || at_last);

  assign busy = (state == RUN) || !empty;

  // Returns {M, D, SI} for one beat; SHIFT sends the pattern MSB first, repeating every 4 beats
  function automatic logic [6:0] beat_outputs(input logic [1:0] f_op, input logic [3:0] f_data,
                                              input logic [1:0] f_b);
    logic [6:0] r;
    r = 7'd0;
    case (f_op)
      OP_LOAD:  r = {OP_LOAD, f_data, 1'b0};
      OP_SHIFT: r = {OP_SHIFT, 4'b0000, f_data[~f_b]};
      OP_ROT:   r = {OP_ROT, 4'b0000, 1'b0};
      default:  r = {OP_HOLD, 4'b0000, 1'b0};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_cnt, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= OP_HOLD;
      cnt   <= 3'd0;
      data  <= 4'd0;
      beat  <= 3'd0;
      M     <= 2'b00;
      D     <= 4'd0;
      SI    <= 1'b0;
      done  <= 1'b0;
    end else if (pop) begin
      state        <= RUN;
      op           <= head_op;
      cnt          <= head_cnt;
      data         <= head_data;
      beat         <= 3'd0;
      {M, D, SI}   <= beat_outputs(head_op, head_data, 2'd0);
      done         <= (head_op == OP_LOAD) || (head_cnt == 3'd0);
    end else if ((state == RUN) && !at_last) begin
      beat       <= next_beat;
      {M, D, SI} <= beat_outputs(op, data, next_beat[1:0]);
      done       <= (next_beat == cnt);
    end else begin
      state <= IDLE;
      beat  <= 3'd0;
      M     <= 2'b00;
      D     <= 4'd0;
      SI    <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shreg_cmd_sequencer.sv
// Directed bench for shreg_cmd_sequencer with a paired shift-register model fed by M/D/SI.
module tb_shreg_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic [1:0] M;
  logic [3:0] D;
  logic       SI;
  logic       done;
  logic       busy;

  logic [3:0] q;
  int checks = 0;
  int errors = 0;
  int acc;
  bit drained;

  shreg_cmd_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .M(M), .D(D), .SI(SI), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift register being driven: shift/rotate left, serial in at the LSB
  always @(posedge clk) begin
    if (reset) q <= 4'd0;
    else case (M)
      2'b01:   q <= D;
      2'b10:   q <= {q[2:0], SI};
      2'b11:   q <= {q[2:0], q[3]};
      default: q <= q;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [2:0] c, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = c;
    cmd_data  = d;
  endtask

  // Checks n consecutive beats already on the outputs, then steps past the last one
  task automatic expect_beats(input string tag, input logic [1:0] m, input logic [3:0] d,
                              input int n, input logic [7:0] si_seq);
    for (int b = 0; b < n; b++) begin
      chk({tag, "_M"}, M, m);
      chk({tag, "_D"}, D, d);
      chk({tag, "_SI"}, SI, si_seq[b]);
      chk({tag, "_done"}, done, (b == n - 1));
      chk({tag, "_busy"}, busy, 1'b1);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_cnt = 3'd0;
    cmd_data = 4'd0;
    tick();
    tick();
    chk("rst_M", M, 2'b00);
    chk("rst_D", D, 4'd0);
    chk("rst_SI", SI, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1'b1);

    // LOAD 1101: one beat, one cycle after acceptance
    present(2'b01, 3'd0, 4'b1101);
    tick();
    cmd_valid = 1'b0;
    chk("load_accept_M", M, 2'b00);
    chk("load_accept_busy", busy, 1'b1);
    tick();
    chk("load_M", M, 2'b01);
    chk("load_D", D, 4'b1101);
    chk("load_done", done, 1'b1);
    tick();
    chk("load_after_M", M, 2'b00);
    chk("load_after_done", done, 1'b0);
    chk("load_after_busy", busy, 1'b0);
    chk("load_q", q, 4'b1101);

    // SHIFT cnt=3 data=1010: SI 1,0,1,0
    present(2'b10, 3'd3, 4'b1010);
    tick();
    cmd_valid = 1'b0;
    tick();
    expect_beats("shift4", 2'b10, 4'd0, 4, 8'b0000_0101);
    chk("shift4_idle_M", M, 2'b00);
    chk("shift4_q", q, 4'b1010);

    // ROTATE cnt=1 from 1010
    present(2'b11, 3'd1, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rot_b0_M", M, 2'b11);
    chk("rot_b0_done", done, 1'b0);
    tick();
    chk("rot_b1_M", M, 2'b11);
    chk("rot_b1_done", done, 1'b1);
    chk("rot_q1", q, 4'b0101);
    tick();
    chk("rot_q2", q, 4'b1010);
    chk("rot_idle_M", M, 2'b00);

    // SHIFT cnt=5 data=0110: SI 0,1,1,0,0,1
    present(2'b10, 3'd5, 4'b0110);
    tick();
    cmd_valid = 1'b0;
    tick();
    expect_beats("shift6", 2'b10, 4'd0, 6, 8'b0010_0110);
    chk("shift6_q", q, 4'b1001);

    // Back-to-back LOAD 0011, ROTATE cnt=0, HOLD cnt=2
    present(2'b01, 3'd0, 4'b0011);
    tick();
    present(2'b11, 3'd0, 4'd0);
    tick();
    chk("b2b_load_M", M, 2'b01);
    chk("b2b_load_D", D, 4'b0011);
    chk("b2b_load_done", done, 1'b1);
    present(2'b00, 3'd2, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_rot_M", M, 2'b11);
    chk("b2b_rot_done", done, 1'b1);
    tick();
    expect_beats("b2b_hold", 2'b00, 4'd0, 3, 8'd0);
    chk("b2b_busy_fall", busy, 1'b0);
    chk("b2b_q", q, 4'b0110);

    // Full FIFO behind a HOLD cnt=7
    present(2'b00, 3'd7, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    present(2'b01, 3'd0, 4'b1001);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    chk("full_accepted", acc, 2);
    chk("full_ready_low", cmd_ready, 1'b0);
    chk("full_hold_last_done", done, 1'b1);
    if (cmd_valid && cmd_ready) acc++;
    tick();
    chk("full_ready_after_pop", cmd_ready, 1'b1);
    chk("full_pop_M", M, 2'b01);
    chk("full_pop_D", D, 4'b1001);
    if (cmd_valid && cmd_ready) acc++;
    tick();
    cmd_valid = 1'b0;
    chk("full_total_accepted", acc, 3);
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      tick();
      if (!busy) drained = 1'b1;
    end
    chk("full_drained", drained, 1'b1);

    // Reset on beat 2 of SHIFT cnt=7 with 2 commands queued
    present(2'b10, 3'd7, 4'b1100);
    tick();
    present(2'b01, 3'd0, 4'b1111);
    tick();
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_b2_M", M, 2'b10);
    chk("abort_b2_SI", SI, 1'b0);
    chk("abort_full_ready", cmd_ready, 1'b0);
    reset = 1'b1;
    present(2'b01, 3'd0, 4'b0111);
    #1;
    chk("abort_ready_in_reset", cmd_ready, 1'b0);
    tick();
    chk("abort_M", M, 2'b00);
    chk("abort_D", D, 4'd0);
    chk("abort_SI", SI, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_quiet_M", M, 2'b00);
      chk("abort_quiet_busy", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
